key_input_conditioner: RTL and testbench

- Conditions the 12 raw keypad inputs (KEY_1..KEY_9, KEY_STAR, KEY_0, KEY_SHARP) before they reach the top-level power FSM, gear logic, steering and horn.
- Per key: two-flop synchroniser, tick-based debounce, registered stable level, and single-cycle press, release and long-press pulses.
- Sits directly upstream of the top-level key consumers.
- Replaces the ad-hoc prev_key edge detection, which is sampled on tick_speed, with one uniform edge source.

---
 rtl/car_sim_pkg.sv | 38 +++
 rtl/key_debounce_cell.sv | 176 +++++++++++++++++
 rtl/key_input_conditioner.sv | 69 ++++++
 tb/tb_key_input_conditioner.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/car_sim_pkg.sv
// -----------------------------------------------------------------------------
// car_sim_pkg
// Shared definitions for the keypad input conditioner.
//   NUM_KEYS_DEFAULT : default number of key lanes
//   KEY_IDX_*        : lane index of each physical key in the key vectors
//   key_state_e      : per-key conditioning state
//   state_level()    : debounced level implied by a cell state
// -----------------------------------------------------------------------------
package car_sim_pkg;

  localparam int NUM_KEYS_DEFAULT = 12;

  localparam int KEY_IDX_1     = 0;
  localparam int KEY_IDX_2     = 1;
  localparam int KEY_IDX_3     = 2;
  localparam int KEY_IDX_4     = 3;
  localparam int KEY_IDX_5     = 4;
  localparam int KEY_IDX_6     = 5;
  localparam int KEY_IDX_7     = 6;
  localparam int KEY_IDX_8     = 7;
  localparam int KEY_IDX_9     = 8;
  localparam int KEY_IDX_STAR  = 9;
  localparam int KEY_IDX_0     = 10;
  localparam int KEY_IDX_SHARP = 11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_PEND   = 2'd1,
    HELD         = 2'd2,
    RELEASE_PEND = 2'd3
  } key_state_e;

  // The key is logically down while held or while a release is still pending.
  function automatic logic state_level(input key_state_e s);
    return (s == HELD) || (s == RELEASE_PEND);
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// -----------------------------------------------------------------------------
// key_debounce_cell
// One key lane: two-flop synchroniser, tick-based debounce FSM, hold timer and
// single-cycle press / release / long-press pulses.
// Optional feature macro: KEY_AUTOREPEAT_EN (press re-pulses every
// REPEAT_TICKS ticks after a long press while the key stays held).
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   i_tick      in   one-clk sample strobe
//   i_raw       in   asynchronous raw key level, 1 = pressed
//   o_level     out  debounced stable level
//   o_level_nxt out  level that o_level takes on the next clk edge
//   o_press     out  one-clk pulse on accepted press (and auto-repeat)
//   o_release   out  one-clk pulse on accepted release
//   o_long      out  one-clk pulse when a hold reaches LONG_TICKS
// -----------------------------------------------------------------------------
module key_debounce_cell
  import car_sim_pkg::*;
#(
  parameter int STABLE_TICKS = 8,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_level,
  output logic o_level_nxt,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  if (STABLE_TICKS < 2 || STABLE_TICKS > 255 || LONG_TICKS <= STABLE_TICKS ||
      LONG_TICKS > 65535 || REPEAT_TICKS < 1 || REPEAT_TICKS > 256) begin : g_param_err
    $error("key_debounce_cell: parameter out of range");
  end

  localparam logic [7:0]  DEB_LAST  = 8'(STABLE_TICKS - 1);
  localparam logic [15:0] HOLD_LAST = 16'(LONG_TICKS - 1);

  logic        r_sync_p0;
  logic        r_sync_p1;
  key_state_e  r_state;
  logic [7:0]  r_deb_cnt;
  logic [15:0] r_hold_cnt;
  logic        r_long_done;
  logic        r_press;
  logic        r_release;
  logic        r_long;

  key_state_e  w_state_nxt;
  logic [7:0]  w_deb_nxt;
  logic [15:0] w_hold_nxt;
  logic        w_long_done_nxt;
  logic        w_press_nxt;
  logic        w_release_nxt;
  logic        w_long_nxt;
  logic        w_level;
  logic        w_differ;

`ifdef KEY_AUTOREPEAT_EN
  localparam logic [7:0] REP_LAST = 8'(REPEAT_TICKS - 1);
  logic [7:0] r_rep_cnt;
  logic [7:0] w_rep_nxt;
`endif

  assign w_level  = state_level(r_state);
  assign w_differ = (r_sync_p1 != w_level);

  always_comb begin
    w_state_nxt     = r_state;
    w_deb_nxt       = r_deb_cnt;
    w_hold_nxt      = r_hold_cnt;
    w_long_done_nxt = r_long_done;
    w_press_nxt     = 1'b0;
    w_release_nxt   = 1'b0;
    w_long_nxt      = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    w_rep_nxt       = r_rep_cnt;
`endif
    if (i_tick) begin
      // Hold timer runs through RELEASE_PEND so a bounce does not restart it;
      // it parks at HOLD_LAST once the long pulse has been issued.
      if (w_level) begin
        if (r_hold_cnt == HOLD_LAST) begin
          if (!r_long_done) begin
            w_long_nxt      = 1'b1;
            w_long_done_nxt = 1'b1;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 16'd1;
        end
      end

      if (!w_differ) begin
        w_deb_nxt = 8'd0;
        if (r_state == PRESS_PEND)
          w_state_nxt = IDLE;
        else if (r_state == RELEASE_PEND)
          w_state_nxt = HELD;
      end else if (r_deb_cnt == DEB_LAST) begin
        w_deb_nxt = 8'd0;
        if (w_level) begin
          w_state_nxt     = IDLE;
          w_release_nxt   = 1'b1;
          w_hold_nxt      = 16'd0;
          w_long_done_nxt = 1'b0;
        end else begin
          w_state_nxt = HELD;
          w_press_nxt = 1'b1;
          w_hold_nxt  = 16'd0;
        end
      end else begin
        w_deb_nxt   = r_deb_cnt + 8'd1;
        w_state_nxt = w_level ? RELEASE_PEND : PRESS_PEND;
      end

`ifdef KEY_AUTOREPEAT_EN
      if (r_state == HELD && r_long_done) begin
        if (r_rep_cnt == REP_LAST) begin
          w_press_nxt = 1'b1;
          w_rep_nxt   = 8'd0;
        end else begin
          w_rep_nxt = r_rep_cnt + 8'd1;
        end
      end
      if (w_long_nxt || w_release_nxt)
        w_rep_nxt = 8'd0;
`endif
    end
  end

  // p0/p1: two-flop synchroniser, then state, counters and pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync_p0   <= 1'b0;
      r_sync_p1   <= 1'b0;
      r_state     <= IDLE;
      r_deb_cnt   <= 8'd0;
      r_hold_cnt  <= 16'd0;
      r_long_done <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      r_sync_p0   <= i_raw;
      r_sync_p1   <= r_sync_p0;
      r_state     <= w_state_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_long_done <= w_long_done_nxt;
      r_press     <= w_press_nxt;
      r_release   <= w_release_nxt;
      r_long      <= w_long_nxt;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (rst)
      r_rep_cnt <= 8'd0;
    else
      r_rep_cnt <= w_rep_nxt;
  end
`endif

  assign o_level     = w_level;
  assign o_level_nxt = state_level(w_state_nxt);
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_long      = r_long;

endmodule

// File: rtl/key_input_conditioner.sv
// -----------------------------------------------------------------------------
// key_input_conditioner
// Conditions the raw keypad inputs (KEY_1..KEY_9, KEY_STAR, KEY_0, KEY_SHARP)
// for the power FSM, gear logic, steering and horn: one independent
// key_debounce_cell per lane plus a registered any-key flag.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat of key_press after a
// long press; see key_debounce_cell).
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   tick_sample  in   one-clk sample strobe (tick_scan)
//   key_raw      in   [NUM_KEYS] asynchronous raw key levels, 1 = pressed
//   key_level    out  [NUM_KEYS] debounced stable level
//   key_press    out  [NUM_KEYS] one-clk pulse on accepted 0->1
//   key_release  out  [NUM_KEYS] one-clk pulse on accepted 1->0
//   key_long     out  [NUM_KEYS] one-clk pulse when a hold reaches LONG_TICKS
//   any_key      out  OR of key_level, registered
// -----------------------------------------------------------------------------
module key_input_conditioner
  import car_sim_pkg::*;
#(
  parameter int NUM_KEYS     = NUM_KEYS_DEFAULT,
  parameter int STABLE_TICKS = 8,
  parameter int LONG_TICKS   = 500,
  parameter int REPEAT_TICKS = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_sample,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic                any_key
);

  logic [NUM_KEYS-1:0] w_level_nxt;
  logic                r_any_key;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .STABLE_TICKS (STABLE_TICKS),
      .LONG_TICKS   (LONG_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .i_tick      (tick_sample),
      .i_raw       (key_raw[i]),
      .o_level     (key_level[i]),
      .o_level_nxt (w_level_nxt[i]),
      .o_press     (key_press[i]),
      .o_release   (key_release[i]),
      .o_long      (key_long[i])
    );
  end

  // Built from the cells' next levels so any_key moves in the same clk as key_level.
  always_ff @(posedge clk) begin
    if (rst)
      r_any_key <= 1'b0;
    else
      r_any_key <= |w_level_nxt;
  end

  assign any_key = r_any_key;

endmodule

// File: tb/tb_key_input_conditioner.sv
module tb_key_input_conditioner;

  localparam int NK = 12;

`ifdef KEY_AUTOREPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_sample = 1'b0;
  logic [NK-1:0] key_raw = '0;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;
  logic          any_key;

  int errors = 0;
  int checks = 0;
  int tick_n = 0;
  int ph = 0;
  int cnt_press [NK];
  int cnt_rel   [NK];
  int cnt_long  [NK];

  key_input_conditioner #(
    .NUM_KEYS     (NK),
    .STABLE_TICKS (4),
    .LONG_TICKS   (10),
    .REPEAT_TICKS (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_sample (tick_sample),
    .key_raw     (key_raw),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .any_key     (any_key)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the edge, outputs sampled there too.
  task automatic clk1();
    logic was_tick;
    was_tick = tick_sample;
    @(posedge clk);
    #1;
    if (was_tick) tick_n++;
    for (int i = 0; i < NK; i++) begin
      cnt_press[i] += int'(key_press[i]);
      cnt_rel[i]   += int'(key_release[i]);
      cnt_long[i]  += int'(key_long[i]);
    end
    ph = (ph + 1) % 4;
    tick_sample = (ph == 0);
  endtask

  // Run until n more tick edges have passed; returns just after the last one.
  task automatic ticks(input int n);
    int target;
    target = tick_n + n;
    while (tick_n < target) clk1();
  endtask

  initial begin
    for (int i = 0; i < NK; i++) begin
      cnt_press[i] = 0;
      cnt_rel[i]   = 0;
      cnt_long[i]  = 0;
    end

    // Reset state
    repeat (3) clk1();
    check("rst_level",   32'(key_level),   32'h0);
    check("rst_press",   32'(key_press),   32'h0);
    check("rst_release", 32'(key_release), 32'h0);
    check("rst_long",    32'(key_long),    32'h0);
    check("rst_any",     32'(any_key),     32'h0);
    rst = 1'b0;
    ticks(1);

    // Test 1: clean press and release of lane 0
    key_raw[0] = 1'b1;
    ticks(3);
    check("t1_level_early", 32'(key_level), 32'h0);
    check("t1_press_early", 32'(cnt_press[0]), 32'd0);
    ticks(1);
    check("t1_press",  32'(key_press), 32'h001);
    check("t1_level",  32'(key_level), 32'h001);
    check("t1_any",    32'(any_key),   32'h1);
    clk1();
    check("t1_press_1clk", 32'(key_press), 32'h0);
    check("t1_level_hold", 32'(key_level), 32'h001);
    ticks(1);
    key_raw[0] = 1'b0;
    ticks(3);
    check("t1_level_before_rel", 32'(key_level), 32'h001);
    ticks(1);
    check("t1_release",     32'(key_release),   32'h001);
    check("t1_level_rel",   32'(key_level),     32'h0);
    check("t1_any_rel",     32'(any_key),       32'h0);
    check("t1_press_count", 32'(cnt_press[0]),  32'd1);
    check("t1_no_long",     32'(cnt_long[0]),   32'd0);

    // Test 2: bounce on lane 3 restarts the debounce count
    key_raw[3] = 1'b1;
    ticks(3);
    key_raw[3] = 1'b0;
    ticks(1);
    check("t2_no_accept", 32'(key_level), 32'h0);
    key_raw[3] = 1'b1;
    ticks(3);
    check("t2_level_early", 32'(key_level), 32'h0);
    check("t2_press_early", 32'(cnt_press[3]), 32'd0);
    ticks(1);
    check("t2_press",       32'(key_press),    32'h008);
    check("t2_press_count", 32'(cnt_press[3]), 32'd1);
    key_raw[3] = 1'b0;
    ticks(4);
    check("t2_release", 32'(key_release), 32'h008);

    // Test 3: long press on lane 10 (KEY_0)
    key_raw[10] = 1'b1;
    ticks(4);
    check("t3_press", 32'(key_press), 32'h400);
    ticks(9);
    check("t3_long_early", 32'(cnt_long[10]), 32'd0);
    ticks(1);
    check("t3_long",        32'(key_long), 32'h400);
    check("t3_long_level",  32'(key_level), 32'h400);
    ticks(3);
    check("t3_repeat_13", 32'(key_press[10]), 32'(REP_ON));
    ticks(3);
    check("t3_repeat_16", 32'(key_press[10]), 32'(REP_ON));
    key_raw[10] = 1'b0;
    ticks(4);
    check("t3_release",     32'(key_release),   32'h400);
    check("t3_long_once",   32'(cnt_long[10]),  32'd1);
    check("t3_rel_once",    32'(cnt_rel[10]),   32'd1);
    check("t3_press_count", 32'(cnt_press[10]), 32'(1 + 2 * REP_ON));

    // Test 4: simultaneous press on lanes 2 and 7
    key_raw[2] = 1'b1;
    key_raw[7] = 1'b1;
    ticks(4);
    check("t4_press_both", 32'(key_press), 32'h084);
    check("t4_level_both", 32'(key_level), 32'h084);
    check("t4_any",        32'(any_key),   32'h1);
    key_raw[2] = 1'b0;
    ticks(4);
    check("t4_release_2", 32'(key_release), 32'h004);
    check("t4_any_one",   32'(any_key),     32'h1);
    key_raw[7] = 1'b0;
    ticks(3);
    check("t4_any_pending", 32'(any_key), 32'h1);
    ticks(1);
    check("t4_release_7", 32'(key_release), 32'h080);
    check("t4_any_off",   32'(any_key),     32'h0);

    // Test 5: reset during PRESS_PEND of lane 5 while lane 9 is held
    key_raw[9] = 1'b1;
    ticks(4);
    check("t5_press_9", 32'(key_press), 32'h200);
    key_raw[5] = 1'b1;
    ticks(2);
    rst = 1'b1;
    clk1();
    check("t5_rst_level", 32'(key_level), 32'h0);
    check("t5_rst_any",   32'(any_key),   32'h0);
    check("t5_rst_press", 32'(key_press), 32'h0);
    ticks(1);
    check("t5_rst_tick_level", 32'(key_level), 32'h0);
    rst = 1'b0;
    ticks(3);
    check("t5_level_early", 32'(key_level), 32'h0);
    ticks(1);
    check("t5_press_after", 32'(key_press), 32'h220);
    check("t5_level_after", 32'(key_level), 32'h220);
    key_raw = '0;
    ticks(4);
    check("t5_release", 32'(key_release), 32'h220);
    check("t5_any_end", 32'(any_key),     32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
